input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
//
// PURPOSE
// - Conditions a raw, asynchronous, bouncy input (push-button/switch) into a clean, synchronous level.
// - Sits directly upstream of fsmFlipFlop: D drives its D input, and both blocks share clk.
// - Flow: multi-stage synchroniser, then a stability counter with a 4-state FSM.
//   An input change propagates only after it has held for STABLE_CYCLES consecutive clocks.
//
// PARAMETERS
// - SYNC_STAGES    2     synchroniser depth; legal range >= 2
// - STABLE_CYCLES  1000  consecutive synchronised cycles required to accept a new level; >= 1
// - CNT_WIDTH      16    stability counter width; STABLE_CYCLES-1 must fit in it
//
// PORTS
// - clk   input   1  clock; all state updates on the rising edge
// - nRst  input   1  asynchronous reset, active-low
// - din   input   1  raw asynchronous input
// - D     output  1  debounced, synchronous level (feeds the flip-flop D input)
// - nD    output  1  always ~D
// - rise  output  1  one-cycle pulse when D goes 0->1 (only with DEBOUNCE_EDGE_EN)
// - fall  output  1  one-cycle pulse when D goes 1->0 (only with DEBOUNCE_EDGE_EN)
//
// BEHAVIOUR
// - Reset: nRst low clears all state immediately, with no clock edge required:
//   - sync chain = 0, state = STABLE_LO, cnt = 0
//   - D = 0, nD = 1, rise = 0, fall = 0
//   - While nRst is low, din is ignored.
// - Synchroniser: din passes through SYNC_STAGES flops; s = last stage. No logic before the first flop.
// - FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO. D = 1 in STABLE_HI and PEND_LO.
//   - STABLE_LO: if s=1, go to PEND_HI with cnt=1 (or, if STABLE_CYCLES=1, go to STABLE_HI directly).
//   - PEND_HI:
//     - s=0: go to STABLE_LO, cnt=0 (glitch rejected, no output change).
//     - s=1 and cnt==STABLE_CYCLES-1: go to STABLE_HI, cnt=0.
//     - otherwise: cnt++.
//   - STABLE_HI and PEND_LO mirror the above with the polarity inverted.
// - Latency: take edge 1 as the first rising edge that samples a new din value, with din held afterwards.
//   D changes on edge SYNC_STAGES+STABLE_CYCLES; e.g. edge 6 for the values 2/4.
// - Any reversion of s during PEND restarts qualification from zero. The counter never wraps:
//   it is reset before it can reach STABLE_CYCLES.
// - D and nD are registered, never combinational from din. They change on the same edge, with no skew cycle.
// - Reset mid-PEND: the partial count is discarded. After release, full qualification is required again.
// - din toggling on every cycle indefinitely: D holds its last stable value forever.
//
// CONFIGURATION
// - Macro: DEBOUNCE_EDGE_EN.
// - Defined:
//   - rise/fall ports exist.
//   - rise=1 for exactly one cycle, registered on the same edge that D goes 0->1; fall likewise for 1->0.
//   - rise and fall are never both 1. Both reset to 0.
// - Undefined: rise/fall ports and their logic are absent. D/nD behaviour is identical.
//
// TESTING (SYNC_STAGES=2, STABLE_CYCLES=4, DEBOUNCE_EDGE_EN defined)
// - Reset: nRst=0 mid-cycle with din=1 -> D=0, nD=1, rise=fall=0 before the next edge.
//   After release, with din held at 1 -> D=1 at edge 6.
// - Glitch: din=1 for 3 cycles, then 0 -> D remains 0 throughout; rise never asserts.
// - Clean rise: din 0->1, held -> D=1, nD=0 after edge 6; rise=1 for edges 6-7 only.
//   Then din 1->0, held -> D=0 after edge 6; fall pulses once.
// - Bounce: din toggles every 2 cycles for 20 cycles, then holds at 1
//   -> exactly one rise pulse, 6 edges after the final transition.
// - Reset mid-PEND_HI (cnt=2): assert nRst asynchronously -> D stays 0 and cnt=0.
//   After release, with din=1 -> 6 more edges are needed before D=1.
// - Chained with fsmFlipFlop on a shared clk: the flip-flop Q follows D one clock later. nQ = ~Q throughout.

Source files
------------

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//   Turns a raw, asynchronous, bouncy input (push-button or switch) into a
//   clean level that is synchronous to clk. The debounced level D feeds the
//   D input of the downstream flip-flop, which runs on the same clk.
//
//   din first passes through a SYNC_STAGES-deep synchroniser. A 4-state FSM
//   with a stability counter then accepts a new level only once the
//   synchronised value has held for STABLE_CYCLES consecutive clocks.
//
// Ports
//   clk   in   clock; all state updates on the rising edge
//   nRst  in   asynchronous reset, active-low
//   din   in   raw asynchronous input
//   D     out  debounced level (registered)
//   nD    out  always ~D
//   rise  out  one-cycle pulse when D goes 0->1 (DEBOUNCE_EDGE_EN only)
//   fall  out  one-cycle pulse when D goes 1->0 (DEBOUNCE_EDGE_EN only)
//
// Build option
//   DEBOUNCE_EDGE_EN  when defined, adds the rise/fall ports and their logic.
//                     D/nD behave the same either way.
//
// States
//   STABLE_LO | D=0 and settled
//   PEND_HI   | D=0, s=1 is being qualified
//   STABLE_HI | D=1 and settled
//   PEND_LO   | D=1, s=0 is being qualified
// ---------------------------------------------------------------------------
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic din,
  output logic D,
  output logic nD
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   d_q, d_d;

  // The first stage samples din directly; nothing sits ahead of it.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      d_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
    end
  end

  // cnt counts cycles the pending level has already held, so the pending
  // state is left on reaching STABLE_CYCLES-1; the counter cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else begin
            state_d = PEND_HI;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else begin
            state_d = PEND_LO;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    // D is decoded from the next state and registered, so it updates on the
    // same edge as the state change.
    d_d = (state_d == STABLE_HI) || (state_d == PEND_LO);
  end

  assign D  = d_q;
  assign nD = ~d_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= d_d & ~d_q;
      fall_q <= ~d_d & d_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic din = 1'b0;
  logic D, nD;
`ifdef DEBOUNCE_EDGE_EN
  logic rise, fall;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: a delay line for the synchroniser and a run length of
  // consecutive cycles where the delayed input disagrees with the output.
  logic m_pipe [SYNC];
  logic m_d = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  int   m_run = 0;
  logic prev_d = 1'b0;
  int   d_rises = 0;
  int   d_falls = 0;

  input_debouncer #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_WIDTH    (4)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .din (din),
    .D   (D),
    .nD  (nD)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .rise(rise),
    .fall(fall)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
    m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (D === m_d) else begin
      failures++; $error("FAIL %s D got=%b exp=%b", tag, D, m_d);
    end
    checks++;
    assert (nD === ~m_d) else begin
      failures++; $error("FAIL %s nD got=%b exp=%b", tag, nD, ~m_d);
    end
`ifdef DEBOUNCE_EDGE_EN
    checks++;
    assert (rise === m_rise) else begin
      failures++; $error("FAIL %s rise got=%b exp=%b", tag, rise, m_rise);
    end
    checks++;
    assert (fall === m_fall) else begin
      failures++; $error("FAIL %s fall got=%b exp=%b", tag, fall, m_fall);
    end
`endif
  endtask

  // One clock: advance the model on the edge, then compare 1 time unit later.
  task automatic tick(input string tag);
    logic s;
    @(posedge clk);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (nRst) begin
      s = m_pipe[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = din;
      if (s != m_d) begin
        m_run++;
        if (m_run == STABLE) begin
          m_d = s; m_run = 0;
          if (s) m_rise = 1'b1; else m_fall = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
    check_outputs(tag);
    if (D === 1'b1 && prev_d === 1'b0) d_rises++;
    if (D === 1'b0 && prev_d === 1'b1) d_falls++;
    prev_d = D;
  endtask

  task automatic edges_until_d(input logic lvl, input string tag, output int n);
    n = 0;
    while (D !== lvl && n < 30) begin
      tick(tag);
      n++;
    end
  endtask

  initial begin
    int n;
    model_reset();

    // Reset held with din=1: output stays low.
    din = 1'b1;
    repeat (3) tick("in_reset");
    checks++;
    assert (D === 1'b0 && nD === 1'b1) else begin
      failures++; $error("FAIL reset_hold D/nD got=%b/%b exp=0/1", D, nD);
    end
    nRst = 1'b1;
    edges_until_d(1'b1, "post_reset", n);
    checks++;
    assert (n == SYNC + STABLE) else begin
      failures++; $error("FAIL post_reset_latency got=%0d exp=%0d", n, SYNC + STABLE);
    end

    // Asynchronous reset mid-cycle clears D with no clock edge.
    #2 nRst = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    tick("in_reset2");
    #2 nRst = 1'b1;

    // Glitch: 3 cycles high is not enough.
    din = 1'b0;
    repeat (8) tick("settle_lo");
    d_rises = 0;
    din = 1'b1;
    repeat (3) tick("glitch_hi");
    din = 1'b0;
    repeat (8) tick("glitch_lo");
    checks++;
    assert (d_rises == 0) else begin
      failures++; $error("FAIL glitch_rises got=%0d exp=0", d_rises);
    end

    // Clean rise then clean fall.
    din = 1'b1;
    edges_until_d(1'b1, "clean_rise", n);
    checks++;
    assert (n == 6) else begin
      failures++; $error("FAIL clean_rise_latency got=%0d exp=6", n);
    end
    repeat (3) tick("hold_hi");
    din = 1'b0;
    edges_until_d(1'b0, "clean_fall", n);
    checks++;
    assert (n == 6) else begin
      failures++; $error("FAIL clean_fall_latency got=%0d exp=6", n);
    end
    repeat (3) tick("hold_lo");

    // Bounce: toggles every 2 cycles for 20 cycles, then holds high.
    d_rises = 0;
    for (int seg = 0; seg < 10; seg++) begin
      din = (seg % 2 == 0) ? 1'b1 : 1'b0;
      repeat (2) tick("bounce");
    end
    checks++;
    assert (d_rises == 0 && D === 1'b0) else begin
      failures++; $error("FAIL bounce_hold rises=%0d D=%b exp 0/0", d_rises, D);
    end
    din = 1'b1;
    edges_until_d(1'b1, "bounce_final", n);
    checks++;
    assert (n == 6) else begin
      failures++; $error("FAIL bounce_latency got=%0d exp=6", n);
    end
    repeat (6) tick("bounce_after");
    checks++;
    assert (d_rises == 1) else begin
      failures++; $error("FAIL bounce_rise_count got=%0d exp=1", d_rises);
    end

    // Reset while PEND_HI with cnt=2.
    din = 1'b0;
    repeat (10) tick("to_lo");
    din = 1'b1;
    repeat (4) tick("pend");
    checks++;
    assert (dut.cnt_q === 4'd2) else begin
      failures++; $error("FAIL pend_cnt got=%0d exp=2", dut.cnt_q);
    end
    #2 nRst = 1'b0;
    model_reset();
    #1;
    check_outputs("reset_pend");
    checks++;
    assert (dut.cnt_q === 4'd0) else begin
      failures++; $error("FAIL reset_pend_cnt got=%0d exp=0", dut.cnt_q);
    end
    tick("in_reset3");
    #2 nRst = 1'b1;
    edges_until_d(1'b1, "pend_requal", n);
    checks++;
    assert (n == 6) else begin
      failures++; $error("FAIL pend_requal_latency got=%0d exp=6", n);
    end

    // Randomised hold lengths against the model.
    for (int i = 0; i < 60; i++) begin
      din = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
